// File: rtl/frame_buffer_scanout_controller.sv
// Raster timing generator and front-buffer reader for a dual frame buffer display path.
// Optional macro SCANOUT_TEST_PATTERN_EN adds i_test_pattern, which replaces RAM pixels with h^v.
module frame_buffer_scanout_controller #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int PIXEL_WIDTH = 8,
  parameter int ADDR_WIDTH  = $clog2(H_ACTIVE * V_ACTIVE)
) (
  input  logic                   i_clk,
  input  logic                   i_arst_n,
  input  logic                   i_rasterization_target,
`ifdef SCANOUT_TEST_PATTERN_EN
  input  logic                   i_test_pattern,
`endif
  output logic                   o_frame_buffer_swap_allowed,
  output logic                   o_rd_en,
  output logic [ADDR_WIDTH-1:0]  o_rd_addr,
  output logic                   o_rd_buffer_sel,
  input  logic [PIXEL_WIDTH-1:0] i_rd_data,
  output logic [PIXEL_WIDTH-1:0] o_pixel,
  output logic                   o_de,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic                   o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last, v_last, at_origin, active, h_in_sync, v_in_sync;
  logic          tp_req;

  assign h_last    = (h_cnt == H_LAST);
  assign v_last    = (v_cnt == V_LAST);
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign h_in_sync = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign v_in_sync = (v_cnt >= VS_START) && (v_cnt < VS_END);

`ifdef SCANOUT_TEST_PATTERN_EN
  assign tp_req = i_test_pattern;
`else
  assign tp_req = 1'b0;
`endif

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would collapse the pipeline stages into one.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Stage 1: read request, buffer latch and timing registered from the counters.
  logic de1, hs1, vs1, fs1;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_rd_en                     <= 1'b0;
      o_rd_addr                   <= '0;
      o_rd_buffer_sel             <= 1'b1;
      o_frame_buffer_swap_allowed <= 1'b0;
      de1                         <= 1'b0;
      hs1                         <= ~HSYNC_POL;
      vs1                         <= ~VSYNC_POL;
      fs1                         <= 1'b0;
    end else begin
      o_rd_en   <= active && !tp_req;
      // Linear address advances once per issued read; no h*V_ACTIVE multiply needed.
      o_rd_addr <= at_origin ? '0 : o_rd_addr + ADDR_WIDTH'(o_rd_en);
      if (at_origin) o_rd_buffer_sel <= ~i_rasterization_target;
      // Last blanking line excluded so a swap settles before the next origin latch.
      o_frame_buffer_swap_allowed <= (v_cnt >= V_ACT) && (v_cnt < V_LAST);
      de1 <= active;
      hs1 <= h_in_sync ? HSYNC_POL : ~HSYNC_POL;
      vs1 <= v_in_sync ? VSYNC_POL : ~VSYNC_POL;
      fs1 <= at_origin;
    end
  end

  logic [PIXEL_WIDTH-1:0] src_pixel;

`ifdef SCANOUT_TEST_PATTERN_EN
  logic [31:0]            pat_full;
  logic [PIXEL_WIDTH-1:0] pat1, pat2;
  logic                   tp1, tp2;

  assign pat_full = 32'(h_cnt) ^ 32'(v_cnt);

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      pat1 <= '0;
      pat2 <= '0;
      tp1  <= 1'b0;
      tp2  <= 1'b0;
    end else begin
      pat1 <= pat_full[PIXEL_WIDTH-1:0];
      pat2 <= pat1;
      tp1  <= i_test_pattern;
      tp2  <= tp1;
    end
  end

  assign src_pixel = tp2 ? pat2 : i_rd_data;
`else
  assign src_pixel = i_rd_data;
`endif

  // Stage 2 waits for RAM data; stage 3 drives the pins.
  logic de2, hs2, vs2, fs2;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      de2           <= 1'b0;
      hs2           <= ~HSYNC_POL;
      vs2           <= ~VSYNC_POL;
      fs2           <= 1'b0;
      o_pixel       <= '0;
      o_de          <= 1'b0;
      o_hsync       <= ~HSYNC_POL;
      o_vsync       <= ~VSYNC_POL;
      o_frame_start <= 1'b0;
    end else begin
      de2           <= de1;
      hs2           <= hs1;
      vs2           <= vs1;
      fs2           <= fs1;
      o_pixel       <= de2 ? src_pixel : '0;
      o_de          <= de2;
      o_hsync       <= hs2;
      o_vsync       <= vs2;
      o_frame_start <= fs2;
    end
  end

endmodule

// File: tb/tb_frame_buffer_scanout_controller.sv
// Bench for frame_buffer_scanout_controller with a 7x6 raster (4x3 active).
// A position-based raster model predicts every output each cycle; literal checks pin the model.
module tb_frame_buffer_scanout_controller;

  localparam int HT = 7;
  localparam int FT = 42;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          target = 1'b0;
  logic          tp = 1'b0;
  logic          swap, rd_en, sel, de, hsync, vsync, fs;
  logic [AW-1:0] rd_addr;
  logic [7:0]    ram_q = 8'h00;
  logic [7:0]    pixel;

  int checks = 0;
  int errors = 0;

  int k = 0;
  logic exp_sel = 1'b1;
  int cnt_rd, cnt_swap, cnt_hs, cnt_vs, fs_n, tp_pix;
  int fs_k[2];
  int pix_q[$];

  frame_buffer_scanout_controller #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIXEL_WIDTH(8)
  ) dut (
    .i_clk(clk),
    .i_arst_n(rst_n),
    .i_rasterization_target(target),
`ifdef SCANOUT_TEST_PATTERN_EN
    .i_test_pattern(tp),
`endif
    .o_frame_buffer_swap_allowed(swap),
    .o_rd_en(rd_en),
    .o_rd_addr(rd_addr),
    .o_rd_buffer_sel(sel),
    .i_rd_data(ram_q),
    .o_pixel(pixel),
    .o_de(de),
    .o_hsync(hsync),
    .o_vsync(vsync),
    .o_frame_start(fs)
  );

  always #5 clk = ~clk;

  // RAM returns its address one cycle after a read; junk otherwise.
  always @(posedge clk) ram_q <= rd_en ? 8'(rd_addr) : 8'hEE;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s at k=%0d: actual=%0d required=%0d", name, k, actual, expected);
    end
  endtask

  function automatic int hpos(input int p);
    return p % HT;
  endfunction

  function automatic int vpos(input int p);
    return (p % FT) / HT;
  endfunction

  function automatic bit act(input int p);
    return (hpos(p) < 4) && (vpos(p) < 3);
  endfunction

  function automatic int lin(input int p);
    return vpos(p) * 4 + hpos(p);
  endfunction

  // Raster model: cycle k shows stage-1 outputs of position k-1 and pins of position k-3.
  initial begin
    int q, r, e_pix;
    bit e_rd, e_de, e_hs, e_vs, e_fs;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        k = 0; exp_sel = 1'b1;
        cnt_rd = 0; cnt_swap = 0; cnt_hs = 0; cnt_vs = 0; fs_n = 0; tp_pix = -1;
        pix_q.delete();
      end else begin
        k++;
        q = k - 1;
        r = k - 3;
        if (q % FT == 0) exp_sel = ~target;
        e_rd = act(q) && !tp;
        check("rd_en", int'(rd_en), int'(e_rd));
        if (e_rd) check("rd_addr", int'(rd_addr), lin(q));
        check("rd_buffer_sel", int'(sel), int'(exp_sel));
        check("swap_allowed", int'(swap), int'(vpos(q) >= 3 && vpos(q) < 5));
        if (r >= 0) begin
          e_de  = act(r);
          e_pix = !e_de ? 0 : (tp ? ((hpos(r) ^ vpos(r)) & 255) : lin(r));
          e_hs  = (hpos(r) != 5);
          e_vs  = (vpos(r) != 4);
          e_fs  = (r % FT == 0);
        end else begin
          e_de = 1'b0; e_pix = 0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
        end
        check("de", int'(de), int'(e_de));
        check("pixel", int'(pixel), e_pix);
        check("hsync", int'(hsync), int'(e_hs));
        check("vsync", int'(vsync), int'(e_vs));
        check("frame_start", int'(fs), int'(e_fs));
        if (rd_en) cnt_rd++;
        if (swap) cnt_swap++;
        if (!hsync) cnt_hs++;
        if (!vsync) cnt_vs++;
        if (fs && fs_n < 2) begin fs_k[fs_n] = k; fs_n++; end
        if (de) pix_q.push_back(int'(pixel));
        if (r == 10) tp_pix = int'(pixel);
      end
    end
  end

  task automatic wait_k(input int n);
    int guard = 0;
    while (k < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (k < n) check("wait_timeout", k, n);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_en"}, int'(rd_en), 0);
    check({tag, "_rd_addr"}, int'(rd_addr), 0);
    check({tag, "_sel"}, int'(sel), 1);
    check({tag, "_pixel"}, int'(pixel), 0);
    check({tag, "_de"}, int'(de), 0);
    check({tag, "_fs"}, int'(fs), 0);
    check({tag, "_swap"}, int'(swap), 0);
    check({tag, "_hsync"}, int'(hsync), 1);
    check({tag, "_vsync"}, int'(vsync), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset asserted between clock edges must take effect without a clock.
    #1 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    repeat (3) @(negedge clk);
    check_reset_values("held_rst");
    rst_n = 1'b1;

    // Two full frames, then literal totals for the window k=1..84.
    wait_k(84);
    check("rd_count_2frames", cnt_rd, 24);
    check("swap_cycles_2frames", cnt_swap, 28);
    check("hsync_low_cycles", cnt_hs, 11);
    check("vsync_low_cycles", cnt_vs, 14);
    check("frame_start_first_k", fs_k[0], 3);
    check("frame_start_second_k", fs_k[1], 45);
    check("pixel_count", pix_q.size(), 24);
    for (int i = 0; i < pix_q.size() && i < 24; i++) check("pixel_seq", pix_q[i], i % 12);

    // Front buffer is latched only at the origin.
    wait_k(100);
    target = 1'b1;
    wait_k(110);
    check("sel_held_midframe", int'(sel), 1);
    wait_k(127);
    check("sel_after_latch", int'(sel), 0);
    wait_k(135);
    target = 1'b0;
    wait_k(140);
    target = 1'b1;
    wait_k(150);
    check("sel_ignores_toggle", int'(sel), 0);
    wait_k(169);
    check("sel_after_double_toggle", int'(sel), 0);

    // Reset at h=2, v=1 (position 219 = 5*42+9) for three clocks.
    wait_k(219);
    rst_n = 1'b0;
    #1 check_reset_values("midline_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_k(1);
    check("restart_rd_en", int'(rd_en), 1);
    check("restart_rd_addr", int'(rd_addr), 0);
    check("restart_sel", int'(sel), 0);
    wait_k(60);
    check("restart_frame_start_k", fs_k[0], 3);

`ifdef SCANOUT_TEST_PATTERN_EN
    @(negedge clk);
    rst_n = 1'b0;
    tp = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_k(50);
    check("tp_rd_count", cnt_rd, 0);
    check("tp_pixel_h3_v1", tp_pix, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
